// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Each conversion shifts one input bit per clock. A value that does not fit in
// DIGITS decimal digits raises ovf, and the result saturates to all 9s.
// Optional feature macro: BCD_BLANK_EN adds the blank[DIGITS-1:0] leading-zero mask.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE. out_valid is high in DONE. While out_valid is
// high and out_ready is low, bcd, ovf and blank do not change. in_valid is
// ignored when the block is not in IDLE.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    binary_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                busy,
`ifdef BCD_BLANK_EN
    output logic [DIGITS-1:0]   blank,
`endif
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(BIN_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    logic [4*DIGITS-1:0] adjusted;
    logic [4*DIGITS-1:0] shifted_digits;
    logic                carry_out;
    logic                ovf_next;
    logic                finish;

    // Add 3 to every digit that is 5 or more, then shift the digit chain left
    // by one and bring in the next binary bit (MSB first).
    always_comb begin
        adjusted = digits_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
            end
        end
        shifted_digits = {adjusted[4*DIGITS-2:0], shift_q[BIN_W-1]};
        carry_out      = adjusted[4*DIGITS-1];
    end

    assign ovf_next = ovf_acc_q | carry_out;
    assign finish   = (state_q == S_CONV) && (cnt_q == '0);

    // Next-state and datapath update: accept in IDLE, shift in CONV, hold in DONE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        digits_d  = digits_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d   = binary_in;
                    digits_d  = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W - 1);
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                digits_d  = shifted_digits;
                ovf_acc_d = ovf_next;
                if (cnt_q == '0) begin
                    // The last shift also loads the result registers.
                    state_d = S_DONE;
                    ovf_d   = ovf_next;
                    bcd_d   = ovf_next ? {DIGITS{4'h9}} : shifted_digits;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including any conversion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            digits_q  <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            digits_q  <= digits_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
    logic              all_zero;

    // Leading-zero mask from the final digits. Digit 0 is never blanked, so a value of 0 still shows "0".
    always_comb begin
        blank_calc = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (shifted_digits[4*i +: 4] == 4'd0);
            blank_calc[i] = all_zero;
        end
    end

    // The blank register loads on the same edge as bcd. On overflow the mask is all 0.
    always_comb begin
        blank_d = blank_q;
        if (finish) begin
            blank_d = ovf_next ? '0 : blank_calc;
        end
    end

    // Blank register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
